// File: rtl/bank_enc_pkg.sv
// Shared constants and helpers for the bank index encoder (reverse path of the
// bank-select decoder).
package bank_enc_pkg;

  localparam int N_BANKS_DEFAULT = 4;
  localparam int IDX_W_DEFAULT   = $clog2(N_BANKS_DEFAULT);

  // Helpers work at a fixed maximum width; callers size-cast to their own N_BANKS.
  localparam int MAX_BANKS = 64;
  localparam int MAX_IDX_W = $clog2(MAX_BANKS);

  function automatic logic [MAX_BANKS-1:0] onehot_of(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_BANKS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input logic [MAX_BANKS-1:0] vec);
    return |(vec & (vec - MAX_BANKS'(1)));
  endfunction

endpackage

// File: rtl/bank_index_encoder_if.sv
// Bank event inputs and the index valid/ready output port of the encoder.
interface bank_index_encoder_if
  import bank_enc_pkg::*;
#(
  parameter int N_BANKS = N_BANKS_DEFAULT
);
  localparam int IDX_W = $clog2(N_BANKS);

  // Transfer happens when out_valid && out_ready; once out_valid rises it stays
  // high with encoder_out stable until that transfer.
  logic [N_BANKS-1:0] encoder_in;
  logic               out_ready;
  logic [IDX_W-1:0]   encoder_out;
  logic               out_valid;
  logic               multi_hot;
  logic               coalesce;

  modport master (
    output encoder_in, out_ready,
    input  encoder_out, out_valid, multi_hot, coalesce
  );

  modport slave (
    input  encoder_in, out_ready,
    output encoder_out, out_valid, multi_hot, coalesce
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set bit of cand at or above rr_ptr, wrapping around.
module rr_priority_pick
  import bank_enc_pkg::*;
#(
  parameter  int N_BANKS = N_BANKS_DEFAULT,
  localparam int IDX_W   = $clog2(N_BANKS)
) (
  input  logic [N_BANKS-1:0] cand,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   i_sel,
  output logic [N_BANKS-1:0] sel_oh
);

  logic [N_BANKS-1:0] rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    rot = '0;
    off = '0;
    // Rotate so rr_ptr lands on bit 0; index arithmetic wraps in IDX_W bits.
    for (int i = 0; i < N_BANKS; i++) begin
      rot[i] = cand[IDX_W'(i) + rr_ptr];
    end
    for (int i = N_BANKS - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any    = |cand;
    i_sel  = off + rr_ptr;
    sel_oh = any ? N_BANKS'(onehot_of(MAX_IDX_W'(i_sel))) : '0;
  end

endmodule

// File: rtl/bank_index_encoder.sv
// Queues per-bank event pulses and returns one binary bank index per transfer,
// arbitrated round-robin; repeated events from a pending bank merge.
module bank_index_encoder
  import bank_enc_pkg::*;
#(
  parameter int N_BANKS = N_BANKS_DEFAULT  // power of two, 2..MAX_BANKS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bank_index_encoder_if.slave  bus
);

  localparam int IDX_W = $clog2(N_BANKS);

  logic [N_BANKS-1:0] pending;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   enc_out_q;
  logic               out_valid_q;
  logic               multi_hot_q;
  logic               coalesce_q;

  logic [N_BANKS-1:0] cand;
  logic               slot_free;
  logic               load;
  logic               any;
  logic [IDX_W-1:0]   i_sel;
  logic [N_BANKS-1:0] sel_oh;

  always_comb begin
    cand      = pending | bus.encoder_in;
    slot_free = !out_valid_q || bus.out_ready;
    load      = slot_free && any;
  end

  rr_priority_pick #(.N_BANKS(N_BANKS)) u_pick (
    .cand   (cand),
    .rr_ptr (rr_ptr),
    .any    (any),
    .i_sel  (i_sel),
    .sel_oh (sel_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      rr_ptr      <= '0;
      enc_out_q   <= '0;
      out_valid_q <= 1'b0;
      multi_hot_q <= 1'b0;
      coalesce_q  <= 1'b0;
    end else begin
      // A bank loaded this cycle leaves the queue; an event in the same cycle
      // for that bank is absorbed by the load rather than re-queued.
      pending     <= cand & ~(load ? sel_oh : '0);
      multi_hot_q <= popcount_gt1(MAX_BANKS'(bus.encoder_in));
      coalesce_q  <= |(bus.encoder_in & pending);
      if (load) begin
        enc_out_q   <= i_sel;
        out_valid_q <= 1'b1;
        rr_ptr      <= i_sel + IDX_W'(1);
      end else if (slot_free) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.encoder_out = enc_out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.multi_hot   = multi_hot_q;
  assign bus.coalesce    = coalesce_q;

endmodule
